// File: rtl/id_hazard_pkg.sv
// id_hazard_pkg: shared register-address type and operand-source encoding for the decode hazard unit
package id_hazard_pkg;
   localparam int REG_AW = 5;
   typedef logic [REG_AW-1:0] reg_addr_t;
   typedef enum logic [1:0] {FWD_SRC, WB_SRC, RF_SRC, ZERO_SRC} fwd_sel_e;
endpackage

// File: rtl/id_fwd_select.sv
// id_fwd_select: one read port's operand resolve (zero, forward window, writeback, pending, regfile).
// ID_HAZARD_STATS_EN adds the fwd_hit output used by the stats counters.
module id_fwd_select
   import id_hazard_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NFWD = 2
) (
   input  reg_addr_t              addr,
   input  logic [XLEN-1:0]        rf_data,
   input  logic [NFWD-1:0]        fwd_valid,
   input  logic [NFWD-1:0]        fwd_ready,
   input  logic [NFWD*REG_AW-1:0] fwd_addr,
   input  logic [NFWD*XLEN-1:0]   fwd_data,
   input  logic                   wb_valid,
   input  reg_addr_t              wb_addr,
   input  logic [XLEN-1:0]        wb_data,
   input  logic                   pending,
   output logic [XLEN-1:0]        data,
   output logic                   stall
`ifdef ID_HAZARD_STATS_EN
   ,
   output logic                   fwd_hit
`endif
);
   logic            hit;
   logic            hit_rdy;
   logic [XLEN-1:0] hit_data;
   fwd_sel_e        sel;
   // scan oldest to youngest so the youngest matching source is the one left standing
   always_comb begin
      hit      = 1'b0;
      hit_rdy  = 1'b0;
      hit_data = '0;
      for (int f = NFWD - 1; f >= 0; f--)
         if (fwd_valid[f] && fwd_addr[f*REG_AW +: REG_AW] == addr) begin
            hit      = 1'b1;
            hit_rdy  = fwd_ready[f];
            hit_data = fwd_data[f*XLEN +: XLEN];
         end
   end
   always_comb begin
      sel   = addr == '0 ? ZERO_SRC : hit ? FWD_SRC : (wb_valid && wb_addr == addr) ? WB_SRC : RF_SRC;
      stall = sel == FWD_SRC ? !hit_rdy : (sel == RF_SRC && pending);
      data  = sel == ZERO_SRC ? '0 : sel == FWD_SRC ? hit_data : sel == WB_SRC ? wb_data : rf_data;
   end
`ifdef ID_HAZARD_STATS_EN
   assign fwd_hit = sel == FWD_SRC && hit_rdy;
`endif
endmodule

// File: rtl/id_hazard_scoreboard.sv
// id_hazard_scoreboard: per-register pending-write counters plus NSRC operand resolvers for decode.
// ID_HAZARD_STATS_EN adds stall_cycles / fwd_hits counters.
module id_hazard_scoreboard
   import id_hazard_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int NREG    = 32,
   parameter int NSRC    = 2,
   parameter int NFWD    = 2,
   parameter int MAXPEND = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   issue_valid,
   input  logic                   issue_we,
   input  logic [REG_AW-1:0]      issue_dest,
   input  logic [NSRC*REG_AW-1:0] src_addr,
   input  logic [NSRC*XLEN-1:0]   src_rf_data,
   input  logic [NFWD-1:0]        fwd_valid,
   input  logic [NFWD-1:0]        fwd_ready,
   input  logic [NFWD*REG_AW-1:0] fwd_addr,
   input  logic [NFWD*XLEN-1:0]   fwd_data,
   input  logic                   wb_valid,
   input  logic [REG_AW-1:0]      wb_addr,
   input  logic [XLEN-1:0]        wb_data,
   output logic [NSRC*XLEN-1:0]   src_data,
   output logic [NSRC-1:0]        src_stall,
   output logic                   stall,
   output logic                   dest_full
`ifdef ID_HAZARD_STATS_EN
   ,
   output logic [31:0]            stall_cycles,
   output logic [31:0]            fwd_hits
`endif
);
   localparam int CW = $clog2(MAXPEND + 1);
   logic [CW-1:0]   pend_q [NREG];
   logic [CW-1:0]   pend_d [NREG];
   logic [NREG-1:0] inc_vec;
   logic [NREG-1:0] dec_vec;
   always_comb begin
      inc_vec = (issue_valid && issue_we && issue_dest != '0) ? NREG'(1) << issue_dest : '0;
      dec_vec = wb_valid ? NREG'(1) << wb_addr : '0;
      for (int r = 0; r < NREG; r++)
         pend_d[r] = (inc_vec[r] && !dec_vec[r] && pend_q[r] != CW'(MAXPEND)) ? pend_q[r] + 1'b1 :
                     (dec_vec[r] && !inc_vec[r] && pend_q[r] != '0) ? pend_q[r] - 1'b1 : pend_q[r];
   end
   always_ff @(posedge clk) begin
      if (rst) pend_q <= '{default: '0};
      else pend_q <= pend_d;
   end
   // protocol checks; a same-cycle issue/retire on one register is legal and nets to zero
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(wb_valid && wb_addr != '0 && pend_q[wb_addr] == '0 && !inc_vec[wb_addr]));
         assert (!(issue_valid && issue_we && dest_full && !dec_vec[issue_dest]));
      end
   end
   assign dest_full = pend_q[issue_dest] == CW'(MAXPEND);
   assign stall     = |src_stall | dest_full;
`ifdef ID_HAZARD_STATS_EN
   logic [NSRC-1:0] fwd_hit;
`endif
   for (genvar s = 0; s < NSRC; s++) begin : g_src
      id_fwd_select #(.XLEN(XLEN), .NFWD(NFWD)) u_sel (
         .addr      (src_addr[s*REG_AW +: REG_AW]),
         .rf_data   (src_rf_data[s*XLEN +: XLEN]),
         .fwd_valid (fwd_valid),
         .fwd_ready (fwd_ready),
         .fwd_addr  (fwd_addr),
         .fwd_data  (fwd_data),
         .wb_valid  (wb_valid),
         .wb_addr   (wb_addr),
         .wb_data   (wb_data),
         .pending   (pend_q[src_addr[s*REG_AW +: REG_AW]] != '0),
         .data      (src_data[s*XLEN +: XLEN]),
         .stall     (src_stall[s])
`ifdef ID_HAZARD_STATS_EN
         ,
         .fwd_hit   (fwd_hit[s])
`endif
      );
   end
`ifdef ID_HAZARD_STATS_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] fwd_hits_q, fwd_hits_d;
   always_comb begin
      stall_cycles_d = stall_cycles_q + {31'd0, stall};
      fwd_hits_d     = fwd_hits_q + {31'd0, |fwd_hit};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= '0;
         fwd_hits_q     <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         fwd_hits_q     <= fwd_hits_d;
      end
   end
   assign stall_cycles = stall_cycles_q;
   assign fwd_hits     = fwd_hits_q;
`endif
endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb_id_hazard_scoreboard: directed vectors checked against a behavioural scoreboard model each cycle
module tb_id_hazard_scoreboard;
   logic        clk = 0;
   logic        rst;
   logic        issue_valid, issue_we;
   logic [4:0]  issue_dest;
   logic [9:0]  src_addr;
   logic [63:0] src_rf_data;
   logic [1:0]  fwd_valid, fwd_ready;
   logic [9:0]  fwd_addr;
   logic [63:0] fwd_data;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [63:0] src_data;
   logic [1:0]  src_stall;
   logic        stall, dest_full;
`ifdef ID_HAZARD_STATS_EN
   logic [31:0] stall_cycles, fwd_hits;
`endif
   int checks = 0;
   int passed = 0;
   bit armed = 0;
   int pend [32];

   id_hazard_scoreboard dut (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_we(issue_we), .issue_dest(issue_dest),
      .src_addr(src_addr), .src_rf_data(src_rf_data), .fwd_valid(fwd_valid), .fwd_ready(fwd_ready),
      .fwd_addr(fwd_addr), .fwd_data(fwd_data), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .src_data(src_data), .src_stall(src_stall), .stall(stall), .dest_full(dest_full)
`ifdef ID_HAZARD_STATS_EN
      , .stall_cycles(stall_cycles), .fwd_hits(fwd_hits)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      else passed++;
   endtask

   // pending-write count per register, straight from the issue/retire rules
   always @(posedge clk)
      if (rst) for (int r = 0; r < 32; r++) pend[r] <= 0;
      else for (int r = 1; r < 32; r++) begin
         if (issue_valid && issue_we && issue_dest == r && !(wb_valid && wb_addr == r))
            pend[r] <= pend[r] < 3 ? pend[r] + 1 : 3;
         else if (wb_valid && wb_addr == r && !(issue_valid && issue_we && issue_dest == r))
            pend[r] <= pend[r] > 0 ? pend[r] - 1 : 0;
      end

   function automatic void resolve(input int s, output bit st, output logic [31:0] d);
      int a = int'(src_addr[s*5 +: 5]);
      st = 0;
      d  = src_rf_data[s*32 +: 32];
      if (a == 0) begin d = 0; return; end
      for (int f = 0; f < 2; f++)
         if (fwd_valid[f] && fwd_addr[f*5 +: 5] == a) begin
            st = !fwd_ready[f];
            d  = fwd_data[f*32 +: 32];
            return;
         end
      if (wb_valid && wb_addr == a) begin d = wb_data; return; end
      st = pend[a] != 0;
   endfunction

   always @(negedge clk)
      if (armed && !rst) begin : cmp
         bit st, any;
         logic [31:0] d;
         any = 0;
         for (int s = 0; s < 2; s++) begin
            resolve(s, st, d);
            chk("m_src_stall", src_stall[s], st);
            if (!st) chk("m_src_data", src_data[s*32 +: 32], d);
            any |= st;
         end
         chk("m_dest_full", dest_full, pend[issue_dest] == 3);
         chk("m_stall", stall, any || pend[issue_dest] == 3);
      end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic look;
      @(negedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1);
   end

   initial begin
      rst = 1; issue_valid = 0; issue_we = 0; issue_dest = 0; src_addr = 0; src_rf_data = 0;
      fwd_valid = 0; fwd_ready = 0; fwd_addr = 0; fwd_data = 0; wb_valid = 0; wb_addr = 0; wb_data = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0; armed = 1;
      // reset pass-through
      src_addr = {5'd5, 5'd3}; src_rf_data = {32'h11, 32'h22};
      look;
      chk("t1_data", src_data, {32'h11, 32'h22});
      chk("t1_stall", stall, 0);
      // load-use through EX forward
      step; issue_valid = 1; issue_we = 1; issue_dest = 5;
      look; chk("t2_full", dest_full, 0);
      step; issue_valid = 0; fwd_valid = 2'b01; fwd_ready = 2'b00; fwd_addr = {5'd0, 5'd5}; src_addr = {5'd3, 5'd5};
      look; chk("t2_wait", src_stall, 2'b01); chk("t2_stall", stall, 1);
      step; fwd_ready = 2'b01; fwd_data = {32'h0, 32'hABCD};
      look; chk("t2_fwd", src_data[31:0], 32'hABCD); chk("t2_go", stall, 0);
      step; fwd_valid = 0; wb_valid = 1; wb_addr = 5; wb_data = 32'h77;
      look; chk("t2_wb", src_data[31:0], 32'h77);
      step; wb_valid = 0;
      look; chk("t2_clear", src_stall, 2'b00); chk("t2_rf", src_data[31:0], 32'h22);
      // youngest forward wins
      step; fwd_valid = 2'b11; fwd_ready = 2'b11; fwd_addr = {5'd7, 5'd7}; fwd_data = {32'h2, 32'h1}; src_addr = {5'd7, 5'd7};
      look; chk("t3_young", src_data, {32'h1, 32'h1});
      // pending beyond window, resolved by same-cycle writeback
      step; fwd_valid = 0; issue_valid = 1; issue_we = 1; issue_dest = 9; src_addr = {5'd3, 5'd9};
      look;
      step; issue_valid = 0;
      look; chk("t4_stall", stall, 1); chk("t4_port", src_stall, 2'b01);
      step; wb_valid = 1; wb_addr = 9; wb_data = 32'h55;
      look; chk("t4_wb", src_data[31:0], 32'h55); chk("t4_go", stall, 0);
      step; wb_valid = 0;
      look; chk("t4_done", stall, 0); chk("t4_rf", src_data[31:0], 32'h22);
      // saturation at MAXPEND
      step; issue_valid = 1; issue_dest = 4; src_addr = {5'd4, 5'd3};
      look; step; look; chk("t5_not_yet", dest_full, 0);
      step; look;
      step; issue_valid = 0;
      look; chk("t5_full", dest_full, 1); chk("t5_stall", stall, 1); chk("t5_port", src_stall, 2'b10);
      step; issue_valid = 1; wb_valid = 1; wb_addr = 4; wb_data = 32'h44;
      look; chk("t5_wbdata", src_data[63:32], 32'h44);
      step; issue_valid = 0; wb_valid = 0;
      look; chk("t5_held", dest_full, 1);
      step; issue_dest = 0;
      look; chk("t5_x0", dest_full, 0);
      step; wb_valid = 1; issue_dest = 4;
      look;
      step; wb_valid = 0;
      look; chk("t5_drain", dest_full, 0); chk("t5_still", src_stall, 2'b10);
      // x0 ignores forwarding, then mid-run reset
      step; src_addr = {5'd3, 5'd0}; fwd_valid = 2'b01; fwd_ready = 2'b00; fwd_addr = {5'd0, 5'd0}; fwd_data = {32'h0, 32'hDEAD};
      look; chk("t6_zero", src_data[31:0], 0); chk("t6_nostall", src_stall[0], 0);
      step; fwd_valid = 0; rst = 1;
      look;
      step; rst = 0; src_addr = {5'd4, 5'd9};
      look; chk("t6_rst_full", dest_full, 0); chk("t6_rst_stall", stall, 0);
      step;
      look;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
